// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: signal bundle between the fetch unit and its neighbours.
//   ex/ctrl side : jump_en_i, jump_addr_i, hold_flag_i
//   imem request : imem_req_valid_o, imem_req_ready_i, imem_addr_o
//   imem response: imem_rsp_valid_i, imem_rsp_data_i
//   if_id side   : inst_valid_o, inst_ready_i, inst_o, inst_addr_o
// Suffixes are relative to the fetch unit. The fetch unit uses the master
// modport; the environment (ex/ctrl, imem, if_id) uses the slave modport.
interface ifu_fetch_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  modport master (
    input  jump_en_i, jump_addr_i, hold_flag_i,
    output imem_req_valid_o, imem_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i,
    output inst_valid_o, inst_o, inst_addr_o,
    input  inst_ready_i
  );

  modport slave (
    output jump_en_i, jump_addr_i, hold_flag_i,
    input  imem_req_valid_o, imem_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i,
    input  inst_valid_o, inst_o, inst_addr_o,
    output inst_ready_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
//   Owns the PC, issues in-order word fetches to imem over a valid/ready
//   request channel and buffers returned words in a DEPTH-entry FIFO that
//   feeds if_id with inst/inst_addr pairs. A redirect from ex flushes the
//   buffer and discards words still in flight.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous reset, active-high
//   bus  - ifu_fetch_if.master (redirect/hold, imem req/rsp, if_id output)
// Parameters:
//   RESET_PC - first fetch address after reset
//   DEPTH    - FIFO entries = max words in flight + buffered (power of 2, >= 2)
// Configuration:
//   IFU_BYPASS_EN - when defined, a non-dropped response arriving at an empty
//   FIFO is presented to if_id combinationally in the same cycle; otherwise
//   the outputs come purely from the FIFO.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW+1:0] DEPTH_C = (CW + 2)'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [CW-1:0] live_cnt, drop_cnt, fifo_cnt;
  logic [AW-1:0] tag_wr, tag_rd, fifo_wr, fifo_rd;
  logic [31:0]   tag_mem       [DEPTH];
  logic [31:0]   fifo_addr_mem [DEPTH];
  logic [31:0]   fifo_data_mem [DEPTH];

  logic          redirect, credit_ok, req_valid, req_fire;
  logic          rsp_drop, rsp_take, fifo_empty, push, pop;
  logic          out_valid;
  logic [31:0]   out_addr, out_data;
  logic [CW+1:0] in_use;
  logic [CW-1:0] fire_w, take_w, push_w, pop_w, rsp_w;
`ifdef IFU_BYPASS_EN
  logic          bypass;
`endif

  always_comb begin
    state_d = state_q;
    if (state_q == BOOT) state_d = RUN;
  end

  always_comb begin
    redirect   = (state_q == RUN) && bus.jump_en_i;
    // Every word requested, not yet dropped, or still buffered holds a FIFO slot,
    // so a response can always be written.
    in_use     = {2'b00, live_cnt} + {2'b00, drop_cnt} + {2'b00, fifo_cnt};
    credit_ok  = in_use < DEPTH_C;
    req_valid  = (state_q == RUN) && !bus.hold_flag_i && !bus.jump_en_i && credit_ok;
    req_fire   = req_valid && bus.imem_req_ready_i;
    rsp_drop   = bus.imem_rsp_valid_i && (drop_cnt != '0);
    rsp_take   = bus.imem_rsp_valid_i && (drop_cnt == '0);
    fifo_empty = (fifo_cnt == '0);
`ifdef IFU_BYPASS_EN
    bypass     = fifo_empty && rsp_take;
    out_valid  = !fifo_empty || bypass;
    out_addr   = fifo_empty ? tag_mem[tag_rd] : fifo_addr_mem[fifo_rd];
    out_data   = fifo_empty ? bus.imem_rsp_data_i : fifo_data_mem[fifo_rd];
    pop        = !fifo_empty && bus.inst_ready_i && !redirect;
    // A bypassed word taken by if_id this cycle never enters the FIFO.
    push       = rsp_take && !redirect && !(bypass && bus.inst_ready_i);
`else
    out_valid  = !fifo_empty;
    out_addr   = fifo_addr_mem[fifo_rd];
    out_data   = fifo_data_mem[fifo_rd];
    pop        = out_valid && bus.inst_ready_i && !redirect;
    push       = rsp_take && !redirect;
`endif
    fire_w     = {{(CW-1){1'b0}}, req_fire};
    take_w     = {{(CW-1){1'b0}}, rsp_take};
    push_w     = {{(CW-1){1'b0}}, push};
    pop_w      = {{(CW-1){1'b0}}, pop};
    rsp_w      = {{(CW-1){1'b0}}, bus.imem_rsp_valid_i};
  end

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_addr_o      = pc_q;
  assign bus.inst_valid_o     = out_valid;
  assign bus.inst_o           = out_valid ? out_data : NOP;
  assign bus.inst_addr_o      = out_valid ? out_addr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        pc_q     <= {bus.jump_addr_i[31:2], 2'b00};
        live_cnt <= '0;
        // A response landing this cycle retires either a pending drop or a
        // live word; both leave one fewer word to discard later.
        drop_cnt <= drop_cnt + live_cnt - rsp_w;
        fifo_cnt <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
        fifo_wr  <= '0;
        fifo_rd  <= '0;
      end else begin
        if (req_fire) begin
          pc_q   <= pc_q + 32'd4;
          tag_wr <= tag_wr + 1'b1;
        end
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
        if (rsp_take) tag_rd <= tag_rd + 1'b1;
        if (push)     fifo_wr <= fifo_wr + 1'b1;
        if (pop)      fifo_rd <= fifo_rd + 1'b1;
        live_cnt <= live_cnt + fire_w - take_w;
        fifo_cnt <= fifo_cnt + push_w - pop_w;
      end
    end
  end

  // Storage arrays need no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= pc_q;
    if (push) begin
      fifo_addr_mem[fifo_wr] <= tag_mem[tag_rd];
      fifo_data_mem[fifo_wr] <= bus.imem_rsp_data_i;
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // imem model: in-order responses, lat cycles after accept (lat=1 is zero-wait).
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;

  always @(posedge clk) begin
    logic        acc;
    logic [31:0] a;
    acc = bus.imem_req_valid_o && bus.imem_req_ready_i && !rst;
    a   = bus.imem_addr_o;
    cyc++;
    if (rst) pend.delete();
    else if (acc) begin
      pend.push_back('{a, cyc + lat - 1});
      acc_log.push_back(a);
    end
    #1;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = word_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
    end
  end

  // if_id model: every accepted word must be the next address in program order.
  logic [31:0] exp_next = 32'h8000_0000;
  int          n_deliv  = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.jump_en_i) exp_next = {bus.jump_addr_i[31:2], 2'b00};
      else if (bus.inst_valid_o && bus.inst_ready_i) begin
        chk("deliver_addr", bus.inst_addr_o, exp_next);
        chk("deliver_data", bus.inst_o, word_of(exp_next));
        exp_next = exp_next + 32'd4;
        n_deliv++;
      end
    end
  end

  task automatic quiesce();
    bus.hold_flag_i = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("quiet_pc", bus.imem_addr_o, exp_next);
    chk1("quiet_no_inst", bus.inst_valid_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a_base, pa;
    logic        pv, pr;
    int          base, d0;

    rst                  = 1'b1;
    bus.jump_en_i        = 1'b0;
    bus.jump_addr_i      = '0;
    bus.hold_flag_i      = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.inst_ready_i     = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk1("rst_req_valid", bus.imem_req_valid_o, 1'b0);
    chk("rst_addr", bus.imem_addr_o, 32'h8000_0000);
    chk1("rst_inst_valid", bus.inst_valid_o, 1'b0);
    chk("rst_inst_nop", bus.inst_o, 32'h0000_0013);
    chk("rst_inst_addr", bus.inst_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk1("boot_no_req", bus.imem_req_valid_o, 1'b0);
    @(negedge clk); #1;
    chk1("run_req_valid", bus.imem_req_valid_o, 1'b1);
    chk("run_first_addr", bus.imem_addr_o, 32'h8000_0000);

    // 1: sequential fetch after reset
    for (int i = 0; i < 20 && !(acc_log.size() >= 3 && n_deliv >= 3); i++) @(negedge clk);
    #1;
    chk1("t1_three_accepts", acc_log.size() >= 3, 1'b1);
    chk1("t1_three_delivered", n_deliv >= 3, 1'b1);
    if (acc_log.size() >= 3) begin
      chk("t1_acc0", acc_log[0], 32'h8000_0000);
      chk("t1_acc1", acc_log[1], 32'h8000_0004);
      chk("t1_acc2", acc_log[2], 32'h8000_0008);
    end

    // 2: if_id back-pressure for 10 cycles
    @(negedge clk);
    bus.inst_ready_i = 1'b0;
    base = acc_log.size();
    repeat (10) @(negedge clk);
    #1;
    chk1("t2_accepts_le_depth", (acc_log.size() - base) <= 2, 1'b1);
    chk1("t2_no_req_when_full", bus.imem_req_valid_o, 1'b0);
    chk1("t2_inst_valid", bus.inst_valid_o, 1'b1);
    chk("t2_head_addr", bus.inst_addr_o, exp_next);
    chk("t2_last_acc", acc_log[acc_log.size() - 1], exp_next + 32'd4);
    d0 = n_deliv;
    @(negedge clk);
    bus.inst_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    #1 chk1("t2_drained", n_deliv >= d0 + 2, 1'b1);

    // 4: hold with one word in flight
    quiesce();
    lat    = 3;
    a_base = exp_next;
    @(negedge clk);
    bus.hold_flag_i = 1'b0;
    #1 chk1("t4_req_one", bus.imem_req_valid_o, 1'b1);
    @(negedge clk);
    bus.hold_flag_i = 1'b1;
    d0 = n_deliv;
    #1 chk("t4_acc_addr", acc_log[acc_log.size() - 1], a_base);
    for (int i = 0; i < 6; i++) begin
      chk1("t4_no_req", bus.imem_req_valid_o, 1'b0);
      chk("t4_pc_held", bus.imem_addr_o, a_base + 32'd4);
      @(negedge clk); #1;
    end
    chk1("t4_inflight_delivered", n_deliv == d0 + 1, 1'b1);

    // 3: redirect with two requests in flight
    quiesce();
    a_base = exp_next;
    @(negedge clk);
    bus.hold_flag_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.jump_en_i   = 1'b1;
    bus.jump_addr_i = 32'h8000_0102;
    base = acc_log.size();
    d0   = n_deliv;
    #1;
    chk1("t3_no_req_jump", bus.imem_req_valid_o, 1'b0);
    chk("t3_inflight0", acc_log[base - 2], a_base);
    chk("t3_inflight1", acc_log[base - 1], a_base + 32'd4);
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    #1 chk("t3_pc_target", bus.imem_addr_o, 32'h8000_0100);
    for (int i = 0; i < 3; i++) begin
      chk1("t3_no_stale_valid", bus.inst_valid_o, 1'b0);
      chk("t3_no_stale_inst", bus.inst_o, 32'h0000_0013);
      chk("t3_no_stale_addr", bus.inst_addr_o, 32'h0);
      @(negedge clk); #1;
    end
    for (int i = 0; i < 15 && n_deliv == d0; i++) @(negedge clk);
    #1;
    chk1("t3_accepted_after_jump", acc_log.size() > base, 1'b1);
    if (acc_log.size() > base) chk("t3_first_target_req", acc_log[base], 32'h8000_0100);
    chk1("t3_target_delivered", n_deliv == d0 + 1, 1'b1);

    // 6: redirect latency with zero-wait imem
    quiesce();
    lat = 1;
    @(negedge clk);
    bus.hold_flag_i = 1'b0;
    bus.jump_en_i   = 1'b1;
    bus.jump_addr_i = 32'h8000_2000;
    #1 chk1("t6_T_no_req", bus.imem_req_valid_o, 1'b0);
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    #1;
    chk1("t6_T1_req", bus.imem_req_valid_o, 1'b1);
    chk("t6_T1_addr", bus.imem_addr_o, 32'h8000_2000);
    chk1("t6_T1_no_inst", bus.inst_valid_o, 1'b0);
    @(negedge clk); #1;
`ifdef IFU_BYPASS_EN
    chk1("t6_T2_valid", bus.inst_valid_o, 1'b1);
    chk("t6_T2_addr", bus.inst_addr_o, 32'h8000_2000);
    @(negedge clk); #1;
    chk1("t6_T3_valid", bus.inst_valid_o, 1'b1);
    chk("t6_T3_addr", bus.inst_addr_o, 32'h8000_2004);
`else
    chk1("t6_T2_valid", bus.inst_valid_o, 1'b0);
    @(negedge clk); #1;
    chk1("t6_T3_valid", bus.inst_valid_o, 1'b1);
    chk("t6_T3_addr", bus.inst_addr_o, 32'h8000_2000);
    chk("t6_T3_data", bus.inst_o, word_of(32'h8000_2000));
`endif

    // 5: request stalls and PC wrap
    quiesce();
    @(negedge clk);
    bus.hold_flag_i = 1'b0;
    bus.jump_en_i   = 1'b1;
    bus.jump_addr_i = 32'hFFFF_FFF8;
    base = acc_log.size();
    @(negedge clk);
    bus.jump_en_i = 1'b0;
    pv = 1'b0;
    pr = 1'b1;
    pa = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      if (pv && !pr) chk("t5_addr_stable", bus.imem_addr_o, pa);
      bus.imem_req_ready_i = ~bus.imem_req_ready_i;
      pv = bus.imem_req_valid_o;
      pr = bus.imem_req_ready_i;
      pa = bus.imem_addr_o;
    end
    bus.imem_req_ready_i = 1'b1;
    chk1("t5_enough_accepts", acc_log.size() >= base + 3, 1'b1);
    if (acc_log.size() >= base + 3) begin
      chk("t5_acc_fff8", acc_log[base], 32'hFFFF_FFF8);
      chk("t5_acc_fffc", acc_log[base + 1], 32'hFFFF_FFFC);
      chk("t5_acc_wrap", acc_log[base + 2], 32'h0000_0000);
    end
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
